// File: rtl/clk_cal_pkg.sv
// Shared types and helpers for the clock-delay-chain tap calibration controller.
package clk_cal_pkg;

  // Calibration sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAIL   = 3'd5
  } cal_state_t;

  // Width of a tap index; a single-tap chain still needs one select bit.
  function automatic int tap_w(input int num_taps);
    return (num_taps <= 2) ? 1 : $clog2(num_taps);
  endfunction

  // Width of a counter that must reach max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Early vote wins when the count of early samples exceeds this value.
  function automatic int vote_thresh(input int samples);
    return samples / 2;
  endfunction

endpackage

// File: rtl/pd_vote_acc.sv
// Majority-vote accumulator for the phase detector early flag.
module pd_vote_acc
  import clk_cal_pkg::*;
#(
  parameter int SAMPLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic pd_early,
  output logic vote_early
);

  localparam int CW = cnt_w(SAMPLES);
  localparam logic [CW-1:0] THRESH = CW'(vote_thresh(SAMPLES));

  logic [CW-1:0] ones;

  // Count early samples while enabled; clear takes priority so a new tap starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
    end else if (clear) begin
      ones <= '0;
    end else if (en) begin
      ones <= ones + CW'(pd_early);
    end
  end

  assign vote_early = (ones > THRESH);

endmodule

// File: rtl/clk_tap_cal_ctrl.sv
// Tap calibration controller: sweeps the delay-chain tap upward until the phase
// detector reports the delayed clock is no longer early, then locks that tap.
module clk_tap_cal_ctrl
  import clk_cal_pkg::*;
#(
  parameter int NUM_TAPS    = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int SAMPLES     = 5,
  parameter int DEFAULT_TAP = 0,
  localparam int TAP_W      = tap_w(NUM_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cal_start,
  input  logic             pd_early,
  output logic [TAP_W-1:0] tap_sel,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] locked_tap
);

  // One phase counter serves both the settle wait and the sample window.
  localparam int PHASE_MAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
  localparam int PW        = cnt_w(PHASE_MAX);

  localparam logic [PW-1:0]    SETTLE_LAST = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0]    SAMPLE_LAST = PW'(SAMPLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W-1:0] TAP_DEF     = TAP_W'(DEFAULT_TAP);

  cal_state_t    state;
  logic [PW-1:0] phase_cnt;
  logic          vote_early;

  // The accumulator is held clear through settling so every tap is voted on fresh samples.
  pd_vote_acc #(
    .SAMPLES (SAMPLES)
  ) u_vote (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == ST_SETTLE),
    .en         (state == ST_SAMPLE),
    .pd_early   (pd_early),
    .vote_early (vote_early)
  );

  // Sequencer: tap register only moves on start, advance and fail-revert transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      tap_sel    <= TAP_DEF;
      locked_tap <= TAP_DEF;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
    end else begin
      cal_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cal_start) begin
            tap_sel   <= '0;
            cal_busy  <= 1'b1;
            cal_fail  <= 1'b0;
            phase_cnt <= '0;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (phase_cnt == SETTLE_LAST) begin
            phase_cnt <= '0;
            state     <= ST_SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        ST_SAMPLE: begin
          if (phase_cnt == SAMPLE_LAST) begin
            phase_cnt <= '0;
            state     <= ST_EVAL;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        ST_EVAL: begin
          if (vote_early) begin
            if (tap_sel == TAP_LAST) begin
              // Still early at maximum delay: give up rather than wrap to tap 0.
              state <= ST_FAIL;
            end else begin
              tap_sel   <= tap_sel + TAP_W'(1);
              phase_cnt <= '0;
              state     <= ST_SETTLE;
            end
          end else if (tap_sel == '0) begin
            // Already late at minimum delay: no early-to-late edge exists.
            state <= ST_FAIL;
          end else begin
            locked_tap <= tap_sel;
            cal_done   <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          cal_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_FAIL: begin
          cal_fail <= 1'b1;
          cal_busy <= 1'b0;
          tap_sel  <= locked_tap;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_tap_cal_ctrl.sv
// Self-checking bench for clk_tap_cal_ctrl: directed and randomized per-tap
// phase-detector patterns against a tap-level reference model.
module tb_clk_tap_cal_ctrl;

  localparam int NUM_TAPS    = 8;
  localparam int SETTLE_CYC  = 4;
  localparam int SAMPLES     = 5;
  localparam int DEFAULT_TAP = 0;
  localparam int TAP_W       = 3;
  localparam int PER_TAP     = SETTLE_CYC + SAMPLES + 1;

  logic             clk;
  logic             rst_n;
  logic             cal_start;
  logic             pd_early;
  logic [TAP_W-1:0] tap_sel;
  logic             cal_busy;
  logic             cal_done;
  logic             cal_fail;
  logic [TAP_W-1:0] locked_tap;

  int total;
  int bad;
  int model_locked;

  // Per-tap phase detector pattern; bit j is the j-th sample taken at that tap.
  logic [SAMPLES-1:0] pat [NUM_TAPS];

  clk_tap_cal_ctrl #(
    .NUM_TAPS    (NUM_TAPS),
    .SETTLE_CYC  (SETTLE_CYC),
    .SAMPLES     (SAMPLES),
    .DEFAULT_TAP (DEFAULT_TAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cal_start  (cal_start),
    .pd_early   (pd_early),
    .tap_sel    (tap_sel),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail),
    .locked_tap (locked_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one calibration. Timing is counted in rising edges after the edge that
  // accepts cal_start: tap t is sampled on edges t*PER_TAP+SETTLE_CYC+1 ..
  // t*PER_TAP+SETTLE_CYC+SAMPLES, and the terminating decision lands on edge
  // (kt+1)*PER_TAP. stray_edge pulses cal_start before that edge (0 = none).
  task automatic do_cal(input string tag, input int stray_edge);
    int  kt;
    bit  ok;
    bit  found;
    int  end_n;
    int  t;
    int  r;
    int  exp_tap;
    kt    = NUM_TAPS - 1;
    ok    = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (!found && (2 * $countones(pat[i]) <= SAMPLES)) begin
        found = 1'b1;
        kt    = i;
        ok    = (i != 0);
      end
    end
    end_n = kt * PER_TAP + PER_TAP;

    cal_start = 1'b1;
    pd_early  = 1'($urandom);
    @(posedge clk);
    #1;
    cal_start = 1'b0;
    chk({tag, ".start_busy"}, 32'(cal_busy), 32'd1);
    chk({tag, ".start_tap"},  32'(tap_sel),  32'd0);
    chk({tag, ".start_fail"}, 32'(cal_fail), 32'd0);

    for (int n = 1; n <= end_n + 2; n++) begin
      t = n / PER_TAP;
      r = n % PER_TAP;
      if (t < NUM_TAPS && r >= SETTLE_CYC + 1 && r <= SETTLE_CYC + SAMPLES)
        pd_early = pat[t][r - SETTLE_CYC - 1];
      else
        pd_early = 1'($urandom);
      cal_start = (n == stray_edge);
      @(posedge clk);
      #1;
      cal_start = 1'b0;
      if (n < end_n)       exp_tap = n / PER_TAP;
      else if (n == end_n) exp_tap = kt;
      else                 exp_tap = ok ? kt : model_locked;
      chk($sformatf("%s.tap@%0d", tag, n),  32'(tap_sel),  32'(exp_tap));
      chk($sformatf("%s.busy@%0d", tag, n), 32'(cal_busy), 32'(n <= end_n));
      chk($sformatf("%s.done@%0d", tag, n), 32'(cal_done), 32'(ok && n == end_n));
      chk($sformatf("%s.fail@%0d", tag, n), 32'(cal_fail), 32'(!ok && n > end_n));
    end
    if (ok) model_locked = kt;
    chk({tag, ".locked"}, 32'(locked_tap), 32'(model_locked));
    pd_early = 1'b0;
  endtask

  task automatic set_all(input logic [SAMPLES-1:0] v);
    for (int i = 0; i < NUM_TAPS; i++) pat[i] = v;
  endtask

  initial begin
    int k;
    total        = 0;
    bad          = 0;
    model_locked = DEFAULT_TAP;
    rst_n        = 1'b0;
    cal_start    = 1'b0;
    pd_early     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.tap",    32'(tap_sel),    32'(DEFAULT_TAP));
    chk("rst.locked", 32'(locked_tap), 32'(DEFAULT_TAP));
    chk("rst.busy",   32'(cal_busy),   32'd0);
    chk("rst.done",   32'(cal_done),   32'd0);
    chk("rst.fail",   32'(cal_fail),   32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle.busy", 32'(cal_busy), 32'd0);

    // Late already at tap 0.
    set_all('0);
    do_cal("late_at_0", 0);

    // Early on taps 0..2, late from tap 3.
    set_all('0);
    for (int i = 0; i < 3; i++) pat[i] = '1;
    do_cal("lock_3", 0);

    // Early everywhere: fail and revert to the previous lock.
    set_all('1);
    do_cal("all_early", 0);

    // Noisy votes: tap 2 samples 1,0,1,0,1 is early; tap 3 samples 0,1,0,0,1 is late.
    set_all('0);
    pat[0] = '1;
    pat[1] = '1;
    pat[2] = 5'b10101;
    pat[3] = 5'b10010;
    do_cal("noisy", 0);

    // Second start mid-sample is ignored.
    set_all('0);
    for (int i = 0; i < 5; i++) pat[i] = '1;
    do_cal("restart_mid", PER_TAP + SETTLE_CYC + 3);

    // Start during the DONE cycle is ignored.
    set_all('0);
    pat[0] = '1;
    do_cal("start_in_done", 2 * PER_TAP + 1);

    // Start during the FAIL cycle is ignored.
    set_all('0);
    do_cal("start_in_fail", PER_TAP + 1);

    // Reset asserted while settling at tap 4.
    set_all('1);
    cal_start = 1'b1;
    @(posedge clk);
    #1;
    cal_start = 1'b0;
    pd_early  = 1'b1;
    repeat (4 * PER_TAP + 2) @(posedge clk);
    #1;
    chk("abort.pre_tap", 32'(tap_sel), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.tap",    32'(tap_sel),    32'(DEFAULT_TAP));
    chk("abort.busy",   32'(cal_busy),   32'd0);
    chk("abort.locked", 32'(locked_tap), 32'(DEFAULT_TAP));
    model_locked = DEFAULT_TAP;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    pd_early = 1'b0;
    @(posedge clk);
    #1;
    set_all('0);
    for (int i = 0; i < 3; i++) pat[i] = '1;
    do_cal("after_abort", 0);

    // Randomized patterns: mostly early below a random edge, mostly late above it.
    for (int rep = 0; rep < 8; rep++) begin
      k = $urandom_range(0, NUM_TAPS);
      for (int i = 0; i < NUM_TAPS; i++)
        for (int j = 0; j < SAMPLES; j++)
          pat[i][j] = (i < k) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      do_cal($sformatf("rand%0d", rep), $urandom_range(0, SETTLE_CYC + SAMPLES));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
